// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI initiator and its client-side tests.
package spi_pkg;

    localparam int unsigned MSG_W  = 32;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned ADDR_W = 16;

    // Width of the num_transactions field left over after read bit, code and address.
    function automatic int nt_width(input int unsigned msg_w, input int unsigned code_w,
                                    input int unsigned addr_w);
        return int'(msg_w) - int'(code_w) - int'(addr_w) - 1;
    endfunction

    localparam int NT_W_DEF = nt_width(MSG_W, CODE_W, ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH,
        WAIT_WR,
        DONE
    } spi_server_state_t;

    // Instruction word layout as seen on the wire, MSB first.
    function automatic logic [MSG_W-1:0] pack_instr(input logic              read,
                                                    input logic [CODE_W-1:0] code,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [NT_W_DEF-1:0] num);
        return {read, code, addr, num};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK phase timer: counts HALF_PERIOD-1..0 within each SCK phase and flags the
// last clk cycle of a LOW phase (rise) or a HIGH phase (fall).
module spi_sck_gen #(
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic RST_async,
    input  logic run,
    input  logic high,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] half_cnt;
    logic             phase_end;

    // Reloads whenever stopped so every phase starts with a full half period.
    always_ff @(posedge clk or posedge RST_async) begin
        if (RST_async) begin
            half_cnt <= RELOAD;
        end else if (!run || half_cnt == '0) begin
            half_cnt <= RELOAD;
        end else begin
            half_cnt <= half_cnt - CNT_W'(1);
        end
    end

    assign phase_end = run && (half_cnt == '0);
    assign rise_c    = phase_end && !high;
    assign fall_c    = phase_end && high;

endmodule

// File: rtl/spi_server.sv
// SPI initiator: sends {read,code,start_address,num_transactions}, then streams
// num_transactions words to the client on MOSI or captures them from MISO.
module spi_server
    import spi_pkg::*;
#(
    parameter int unsigned MESSAGE_BIT_WIDTH       = 32,
    parameter int unsigned CODE_BIT_WIDTH          = 4,
    parameter int unsigned START_ADDRESS_BIT_WIDTH = 16,
    parameter int unsigned SCK_HALF_PERIOD         = 2,
    localparam int unsigned NT_W = unsigned'(nt_width(MESSAGE_BIT_WIDTH, CODE_BIT_WIDTH,
                                                      START_ADDRESS_BIT_WIDTH))
) (
    input  logic                               clk,
    input  logic                               RST_async,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_read,
    input  logic [CODE_BIT_WIDTH-1:0]          cmd_code,
    input  logic [START_ADDRESS_BIT_WIDTH-1:0] cmd_start_address,
    input  logic [NT_W-1:0]                    cmd_num_trans,
    input  logic [MESSAGE_BIT_WIDTH-1:0]       wr_data,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    output logic [MESSAGE_BIT_WIDTH-1:0]       rd_data,
    output logic                               rd_valid,
    output logic                               busy,
    output logic                               done,
    output logic                               SCK,
    output logic                               MOSI,
    input  logic                               MISO
);

    localparam int unsigned BIT_W = $clog2(MESSAGE_BIT_WIDTH);
    localparam int unsigned MSB   = MESSAGE_BIT_WIDTH - 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(MESSAGE_BIT_WIDTH - 1);

    if (nt_width(MESSAGE_BIT_WIDTH, CODE_BIT_WIDTH, START_ADDRESS_BIT_WIDTH) < 1) begin : g_bad_nt_w
        $error("spi_server: no room left for num_transactions field");
    end
    if (SCK_HALF_PERIOD < 1) begin : g_bad_half
        $error("spi_server: SCK_HALF_PERIOD must be at least 1");
    end
    if ((1 << BIT_W) != MESSAGE_BIT_WIDTH) begin : g_bad_msg_w
        $error("spi_server: MESSAGE_BIT_WIDTH must be a power of two");
    end

    spi_server_state_t             state;
    logic [MESSAGE_BIT_WIDTH-1:0]  shift_out;
    logic [MESSAGE_BIT_WIDTH-1:0]  shift_in;
    logic [BIT_W-1:0]              bit_cnt;
    logic [NT_W-1:0]               word_cnt;
    logic [NT_W-1:0]               num_q;
    logic                          read_q;
    logic                          rise_c;
    logic                          fall_c;

    spi_sck_gen #(
        .HALF_PERIOD(SCK_HALF_PERIOD)
    ) u_sck_gen (
        .clk      (clk),
        .RST_async(RST_async),
        .run      ((state == LOW) || (state == HIGH)),
        .high     (state == HIGH),
        .rise_c   (rise_c),
        .fall_c   (fall_c)
    );

    // wr_ready pulses the cycle after wr_data has been captured (FIFO pop strobe).
    always_ff @(posedge clk or posedge RST_async) begin
        if (RST_async) begin
            state     <= IDLE;
            SCK       <= 1'b0;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b1;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shift_out <= '0;
            shift_in  <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            num_q     <= '0;
            read_q    <= 1'b0;
        end else begin
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        shift_out <= {cmd_read, cmd_code, cmd_start_address, cmd_num_trans};
                        read_q    <= cmd_read;
                        num_q     <= cmd_num_trans;
                        word_cnt  <= '0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    MOSI  <= shift_out[MSB];
                    state <= LOW;
                end
                LOW: begin
                    if (rise_c) begin
                        SCK   <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall_c) begin
                        SCK      <= 1'b0;
                        shift_in <= {shift_in[MSB-1:0], MISO};
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        if (bit_cnt != LAST_BIT) begin
                            shift_out <= shift_out << 1;
                            MOSI      <= shift_out[MSB-1];
                            state     <= LOW;
                        end else begin
                            // word_cnt==0 means the word just finished was the instruction.
                            if (read_q && word_cnt != '0) begin
                                rd_data  <= {shift_in[MSB-1:0], MISO};
                                rd_valid <= 1'b1;
                            end
                            if (word_cnt == num_q) begin
                                MOSI  <= 1'b0;
                                state <= DONE;
                            end else begin
                                word_cnt <= word_cnt + NT_W'(1);
                                if (read_q) begin
                                    shift_out <= '0;
                                    MOSI      <= 1'b0;
                                    state     <= LOW;
                                end else if (wr_valid) begin
                                    shift_out <= wr_data;
                                    MOSI      <= wr_data[MSB];
                                    wr_ready  <= 1'b1;
                                    state     <= LOW;
                                end else begin
                                    MOSI  <= 1'b0;
                                    state <= WAIT_WR;
                                end
                            end
                        end
                    end
                end
                WAIT_WR: begin
                    if (wr_valid) begin
                        shift_out <= wr_data;
                        MOSI      <= wr_data[MSB];
                        wr_ready  <= 1'b1;
                        state     <= LOW;
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_server.sv
// Directed bench for spi_server against a behavioural spi_client model sharing RST_async.
module tb_spi_server;

    localparam int W = 32;
    localparam int H = 2;
    localparam int NT_W = 11;

    logic            clk = 1'b0;
    logic            RST_async;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_read;
    logic [3:0]      cmd_code;
    logic [15:0]     cmd_start_address;
    logic [NT_W-1:0] cmd_num_trans;
    logic [W-1:0]    wr_data = '0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [W-1:0]    rd_data;
    logic            rd_valid;
    logic            busy;
    logic            done;
    logic            SCK;
    logic            MOSI;
    logic            MISO = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_server #(
        .MESSAGE_BIT_WIDTH(W),
        .CODE_BIT_WIDTH(4),
        .START_ADDRESS_BIT_WIDTH(16),
        .SCK_HALF_PERIOD(H)
    ) dut (
        .clk              (clk),
        .RST_async        (RST_async),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_read         (cmd_read),
        .cmd_code         (cmd_code),
        .cmd_start_address(cmd_start_address),
        .cmd_num_trans    (cmd_num_trans),
        .wr_data          (wr_data),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .busy             (busy),
        .done             (done),
        .SCK              (SCK),
        .MOSI             (MOSI),
        .MISO             (MISO)
    );

    // Client model: samples MOSI on SCK rise, drives MISO on SCK fall.
    int          cl_bit = 0;
    int          cl_left = 0;
    logic        cl_in_data = 1'b0;
    logic        cl_read = 1'b0;
    logic [15:0] cl_addr = '0;
    logic [W-1:0] cl_sh = '0;
    logic [W-1:0] cl_nw = '0;
    logic [W-1:0] cl_instr = '0;
    logic [W-1:0] miso_sh = '0;
    logic [W-1:0] log_data[$];
    logic [W-1:0] log_addr[$];

    always @(posedge SCK or posedge RST_async) begin
        if (RST_async) begin
            cl_bit = 0; cl_left = 0; cl_in_data = 1'b0; cl_read = 1'b0; cl_addr = '0; cl_sh = '0;
        end else begin
            cl_nw = {cl_sh[W-2:0], MOSI};
            cl_sh = cl_nw;
            if (cl_bit == W - 1) begin
                cl_bit = 0;
                if (!cl_in_data) begin
                    cl_instr   = cl_nw;
                    cl_read    = cl_nw[31];
                    cl_addr    = cl_nw[26:11];
                    cl_left    = int'(cl_nw[10:0]);
                    cl_in_data = (cl_left != 0);
                end else begin
                    if (!cl_read) begin
                        log_data.push_back(cl_nw);
                        log_addr.push_back(32'(cl_addr));
                    end
                    cl_addr    = cl_addr + 16'd1;
                    cl_left    = cl_left - 1;
                    cl_in_data = (cl_left != 0);
                end
            end else begin
                cl_bit = cl_bit + 1;
            end
        end
    end

    always @(negedge SCK or posedge RST_async) begin
        if (RST_async) begin
            MISO = 1'b0; miso_sh = '0;
        end else if (cl_in_data && cl_read) begin
            if (cl_bit == 0) miso_sh = {16'hA5A5, cl_addr};
            MISO    = miso_sh[W-1];
            miso_sh = miso_sh << 1;
        end else begin
            MISO = 1'b0;
        end
    end

    // Cumulative monitor and write-word feeder, sampled on the falling clk edge.
    int busy_cycles = 0, sck_high_cycles = 0, wr_ready_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int coincide_cnt = 0, low_run = 0, max_low_run = 0, feed_idx = 0, stall_cycles = 0;
    int hold_at = -1, hold_cycles = 0;
    logic [W-1:0] rd_log[$];
    logic [W-1:0] feed[$];

    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (SCK) sck_high_cycles++;
        if (wr_ready) begin wr_ready_cnt++; feed_idx++; end
        if (rd_valid) begin rd_cnt++; rd_log.push_back(rd_data); end
        if (done) done_cnt++;
        if (rd_valid && done) coincide_cnt++;
        if (busy && !SCK) low_run++; else low_run = 0;
        if (low_run > max_low_run) max_low_run = low_run;
        if (feed_idx == hold_at && low_run > 2 * H && stall_cycles < hold_cycles) stall_cycles++;
        wr_valid = (feed_idx < feed.size()) && !(feed_idx == hold_at && stall_cycles < hold_cycles);
        wr_data  = (feed_idx < feed.size()) ? feed[feed_idx] : '0;
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] log_at(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [W-1:0] addr_at(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [W-1:0] rd_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF;
    endfunction

    int b_busy, b_sck, b_wr, b_rd, b_done, b_coin, b_log, b_rdlog;

    task automatic snap();
        b_busy = busy_cycles; b_sck = sck_high_cycles; b_wr = wr_ready_cnt; b_rd = rd_cnt;
        b_done = done_cnt; b_coin = coincide_cnt; b_log = log_data.size(); b_rdlog = rd_log.size();
    endtask

    task automatic rst_checks(input string tag);
        check_eq({tag, "_ctl"}, 32'({SCK, MOSI, cmd_ready, wr_ready, rd_valid, busy, done}),
                 32'(7'b0010000));
        check_eq({tag, "_rd_data"}, rd_data, '0);
    endtask

    task automatic send_cmd(input logic rd, input logic [3:0] code, input logic [15:0] addr,
                            input logic [NT_W-1:0] num);
        @(posedge clk); #1;
        cmd_read = rd; cmd_code = code; cmd_start_address = addr; cmd_num_trans = num;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_eq(tag, 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        RST_async = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_code = '0;
        cmd_start_address = '0; cmd_num_trans = '0;
        repeat (3) @(negedge clk);
        rst_checks("reset");
        RST_async = 1'b0;
        @(negedge clk);
        rst_checks("idle");

        // 1: write two words
        feed.push_back(32'hDEADBEEF); feed.push_back(32'h12345678);
        snap();
        send_cmd(1'b0, 4'h0, 16'h0010, 11'd2);
        wait_done(2000, "t1_done");
        check_eq("t1_instr", cl_instr, spi_pkg::pack_instr(1'b0, 4'h0, 16'h0010, 11'd2));
        check_eq("t1_nwords", 32'(log_data.size() - b_log), 32'd2);
        check_eq("t1_d0", log_at(b_log), 32'hDEADBEEF);
        check_eq("t1_a0", addr_at(b_log), 32'h0010);
        check_eq("t1_d1", log_at(b_log + 1), 32'h12345678);
        check_eq("t1_a1", addr_at(b_log + 1), 32'h0011);
        check_eq("t1_busy", 32'(busy_cycles - b_busy), 32'd386);
        check_eq("t1_wr_ready", 32'(wr_ready_cnt - b_wr), 32'd2);
        check_eq("t1_done_cnt", 32'(done_cnt - b_done), 32'd1);

        // 2: read three words
        snap();
        send_cmd(1'b1, 4'h3, 16'h0100, 11'd3);
        wait_done(2000, "t2_done");
        check_eq("t2_nrd", 32'(rd_cnt - b_rd), 32'd3);
        check_eq("t2_rd0", rd_at(b_rdlog), 32'hA5A50100);
        check_eq("t2_rd1", rd_at(b_rdlog + 1), 32'hA5A50101);
        check_eq("t2_rd2", rd_at(b_rdlog + 2), 32'hA5A50102);
        check_eq("t2_busy", 32'(busy_cycles - b_busy), 32'd514);
        check_eq("t2_coincide", 32'(coincide_cnt - b_coin), 32'd0);
        check_eq("t2_wr_ready", 32'(wr_ready_cnt - b_wr), 32'd0);

        // 3: instruction word only
        snap();
        send_cmd(1'b0, 4'h5, 16'h0033, 11'd0);
        wait_done(1000, "t3_done");
        check_eq("t3_busy", 32'(busy_cycles - b_busy), 32'(64 * H + 2));
        check_eq("t3_wr_ready", 32'(wr_ready_cnt - b_wr), 32'd0);
        check_eq("t3_rd_valid", 32'(rd_cnt - b_rd), 32'd0);
        check_eq("t3_client_idle", 32'({cl_in_data, cl_bit != 0}), 32'd0);

        // 4: second write word withheld for 50 clks
        feed.push_back(32'hCAFEF00D); feed.push_back(32'h0BADC0DE);
        hold_at = feed.size() - 1;
        hold_cycles = 50;
        snap();
        send_cmd(1'b0, 4'h1, 16'h0020, 11'd2);
        wait_done(3000, "t4_done");
        check_eq("t4_d0", log_at(b_log), 32'hCAFEF00D);
        check_eq("t4_a0", addr_at(b_log), 32'h0020);
        check_eq("t4_d1", log_at(b_log + 1), 32'h0BADC0DE);
        check_eq("t4_a1", addr_at(b_log + 1), 32'h0021);
        check_eq("t4_sck_high", 32'(sck_high_cycles - b_sck), 32'd192);
        check_eq("t4_stall", 32'(stall_cycles), 32'd50);
        check_eq("t4_low_run", 32'(max_low_run >= 50), 32'd1);
        check_eq("t4_busy", 32'(busy_cycles - b_busy >= 436), 32'd1);

        // 5: reset in the middle of a read
        send_cmd(1'b1, 4'h2, 16'h0200, 11'd2);
        repeat (200) @(negedge clk);
        check_eq("t5_mid_busy", 32'(busy), 32'd1);
        RST_async = 1'b1;
        #1;
        rst_checks("t5_rst");
        @(negedge clk);
        RST_async = 1'b0;
        snap();
        send_cmd(1'b1, 4'h2, 16'h0300, 11'd1);
        wait_done(1000, "t5_done");
        check_eq("t5_nrd", 32'(rd_cnt - b_rd), 32'd1);
        check_eq("t5_rd0", rd_at(b_rdlog), 32'hA5A50300);

        // 6: back-to-back commands with cmd_valid held
        feed.push_back(32'h11112222);
        snap();
        @(posedge clk); #1;
        cmd_read = 1'b0; cmd_code = 4'h7; cmd_start_address = 16'h0040; cmd_num_trans = 11'd1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_accept_a", 32'(busy), 32'd1);
        cmd_read = 1'b1; cmd_code = 4'h8; cmd_start_address = 16'h0050; cmd_num_trans = 11'd1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 1000 && !seen; i++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            check_eq("t6_done_a", 32'(seen), 32'd1);
        end
        check_eq("t6_ready_at_done", 32'({cmd_ready, busy}), 32'b10);
        @(posedge clk); #1;
        check_eq("t6_accept_b", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        check_eq("t6_a_data", log_at(b_log), 32'h11112222);
        check_eq("t6_a_addr", addr_at(b_log), 32'h0040);
        wait_done(1000, "t6_done_b");
        check_eq("t6_b_rd", rd_at(b_rdlog), 32'hA5A50050);
        check_eq("t6_done_cnt", 32'(done_cnt - b_done), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
